// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with sequential clear sweep,
// optional register-0 hardwiring, optional write-to-read bypass and a debug read port.
module regfile_mp #(
   parameter  int WIDTH    = 32,
   parameter  int DEPTH    = 32,
   parameter  int NUM_READ = 2,
   parameter  int ZERO_REG = 1,
   parameter  int BYPASS   = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr_req,
   output logic                      ready,
   input  logic                      we,
   input  logic [AW-1:0]             waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [NUM_READ*AW-1:0]    raddr,
   output logic [NUM_READ*WIDTH-1:0] rdata,
   input  logic [AW-1:0]             dbg_addr,
   output logic [WIDTH-1:0]          dbg_data,
   output logic                      wr_drop
);

   localparam logic [AW:0]   DEPTH_C = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);
   localparam int            NP      = NUM_READ + 1;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   state_e           state_q;
   logic [AW-1:0]    cnt_q;
   logic             ready_q;
   logic             wr_drop_q;
   logic [WIDTH-1:0] dbg_q;
   logic [WIDTH-1:0] dbg_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en_s;
   logic [NP*AW-1:0] addr_all_s;

   function automatic logic in_range(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_C);
   endfunction

   function automatic logic is_zero_reg(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign wr_en_s    = we && ready_q && in_range(waddr) && !is_zero_reg(waddr);
   assign addr_all_s = {dbg_addr, raddr};

   // Control FSM: clear sweep, run mode, dropped-write flag and debug capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= '0;
         ready_q   <= 1'b0;
         wr_drop_q <= 1'b0;
         dbg_q     <= '0;
      end else begin
         wr_drop_q <= we & ~ready_q;
         dbg_q     <= dbg_d;
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == LAST_C) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + AW'(1);
               end
            end
            ST_RUN: begin
               if (clr_req) begin
                  state_q <= ST_CLEAR;
                  ready_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               ready_q <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Storage array: the sweep owns the write port while clearing
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_en_s) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Index NUM_READ is the debug port; it shares the read rules including bypass
   for (genvar g = 0; g < NP; g++) begin : g_rd
      logic [AW-1:0]    a_s;
      logic [WIDTH-1:0] val_s;

      assign a_s = addr_all_s[g*AW +: AW];

      // Read priority: not ready, out of range, register 0, bypass, array
      always_comb begin
         val_s = '0;
         if (!ready_q) begin
            val_s = '0;
         end else if (!in_range(a_s)) begin
            val_s = '0;
         end else if (is_zero_reg(a_s)) begin
            val_s = '0;
         end else if ((BYPASS != 0) && we && (a_s == waddr)) begin
            val_s = wdata;
         end else begin
            val_s = mem_q[a_s];
         end
      end

      if (g < NUM_READ) begin : g_port
         assign rdata[g*WIDTH +: WIDTH] = val_s;
      end else begin : g_dbg
         assign dbg_d = val_s;
      end
   end

   assign ready    = ready_q;
   assign wr_drop  = wr_drop_q;
   assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: default configuration (A) alongside a 24-deep, 4-port,
// no-zero-register, no-bypass configuration (B), sharing write/control inputs.
module tb_regfile_mp;

   logic         clk;
   logic         rst_n;
   logic         clr_req;
   logic         we;
   logic [4:0]   waddr;
   logic [31:0]  wdata;
   logic [4:0]   dbg_addr;
   logic [9:0]   raddr_a;
   logic [63:0]  rdata_a;
   logic [31:0]  dbg_a;
   logic         ready_a;
   logic         wr_drop_a;
   logic [19:0]  raddr_b;
   logic [127:0] rdata_b;
   logic [31:0]  dbg_b;
   logic         ready_b;
   logic         wr_drop_b;

   int vectors = 0;
   int errors  = 0;

   regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(2), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_a),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr_a), .rdata(rdata_a),
      .dbg_addr(dbg_addr), .dbg_data(dbg_a), .wr_drop(wr_drop_a)
   );

   regfile_mp #(.WIDTH(32), .DEPTH(24), .NUM_READ(4), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_b),
      .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr_b), .rdata(rdata_b),
      .dbg_addr(dbg_addr), .dbg_data(dbg_b), .wr_drop(wr_drop_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges (numbered from start+1) until each instance reports ready
   task automatic sweep(input int start, input int exp_a, input int exp_b, input string tag);
      int na;
      int nb;
      na = 0;
      nb = 0;
      for (int n = start + 1; n <= start + 40 && (na == 0 || nb == 0); n++) begin
         tick();
         if (ready_a && na == 0) na = n;
         if (ready_b && nb == 0) nb = n;
      end
      chk({tag, "_a"}, 64'(na), 64'(exp_a));
      chk({tag, "_b"}, 64'(nb), 64'(exp_b));
   endtask

   initial begin
      rst_n    = 1'b0;
      clr_req  = 1'b0;
      we       = 1'b0;
      waddr    = 5'd0;
      wdata    = 32'h0;
      dbg_addr = 5'd0;
      raddr_a  = 10'd0;
      raddr_b  = 20'd0;

      // Reset state
      tick();
      tick();
      chk("rst_ready_a", 64'(ready_a), 64'd0);
      chk("rst_ready_b", 64'(ready_b), 64'd0);
      chk("rst_wr_drop", 64'({wr_drop_a, wr_drop_b}), 64'd0);
      chk("rst_dbg_a", 64'(dbg_a), 64'd0);
      rst_n = 1'b1;
      sweep(0, 32, 24, "rst_sweep");

      raddr_a = {5'd0, 5'd5};
      #1;
      chk("swept_r5", 64'(rdata_a[31:0]), 64'h0);

      // Write with same-cycle read: bypass on A, old value on B
      we      = 1'b1;
      waddr   = 5'd7;
      wdata   = 32'hDEADBEEF;
      raddr_a = {5'd7, 5'd7};
      raddr_b = {5'd0, 5'd0, 5'd0, 5'd7};
      #1;
      chk("bypass_a_p0", 64'(rdata_a[31:0]), 64'hDEADBEEF);
      chk("bypass_a_p1", 64'(rdata_a[63:32]), 64'hDEADBEEF);
      chk("nobypass_b", 64'(rdata_b[31:0]), 64'h0);
      tick();
      we = 1'b0;
      #1;
      chk("after_wr_a", 64'(rdata_a[31:0]), 64'hDEADBEEF);
      chk("after_wr_b", 64'(rdata_b[31:0]), 64'hDEADBEEF);
      chk("wr_drop_run", 64'({wr_drop_a, wr_drop_b}), 64'd0);

      // Register 0: hardwired on A, ordinary on B
      we      = 1'b1;
      waddr   = 5'd0;
      wdata   = 32'h12345678;
      raddr_a = {5'd0, 5'd0};
      raddr_b = 20'd0;
      #1;
      chk("zero_wcyc_a", 64'(rdata_a[31:0]), 64'h0);
      chk("zero_wcyc_b", 64'(rdata_b[31:0]), 64'h0);
      tick();
      we = 1'b0;
      #1;
      chk("zero_next_a", 64'(rdata_a[31:0]), 64'h0);
      chk("zero_next_b", 64'(rdata_b[31:0]), 64'h12345678);
      chk("zero_wr_drop", 64'(wr_drop_a), 64'd0);

      // Multi-port read including out-of-range addresses, and debug latency
      we    = 1'b1;
      waddr = 5'd23;
      wdata = 32'h55;
      tick();
      we       = 1'b0;
      raddr_b  = {5'd31, 5'd24, 5'd23, 5'd23};
      dbg_addr = 5'd23;
      #1;
      chk("mp_p0", 64'(rdata_b[31:0]), 64'h55);
      chk("mp_p1", 64'(rdata_b[63:32]), 64'h55);
      chk("mp_p2", 64'(rdata_b[95:64]), 64'h0);
      chk("mp_p3", 64'(rdata_b[127:96]), 64'h0);
      chk("dbg_prev_b", 64'(dbg_b), 64'h12345678);
      chk("dbg_prev_a", 64'(dbg_a), 64'h0);
      tick();
      chk("dbg_b", 64'(dbg_b), 64'h55);
      chk("dbg_a", 64'(dbg_a), 64'h55);
      dbg_addr = 5'd24;
      tick();
      chk("dbg_oor_b", 64'(dbg_b), 64'h0);

      // Clear request with a simultaneous write
      we    = 1'b1;
      waddr = 5'd3;
      wdata = 32'hA5A5A5A5;
      tick();
      waddr = 5'd9;
      tick();
      clr_req = 1'b1;
      waddr   = 5'd4;
      wdata   = 32'h1;
      #1;
      chk("clr_pre_ready", 64'(ready_a), 64'd1);
      tick();
      chk("clr_ready_drop", 64'(ready_a), 64'd0);
      chk("clr_no_drop", 64'(wr_drop_a), 64'd0);
      clr_req = 1'b0;
      we      = 1'b1;
      waddr   = 5'd10;
      wdata   = 32'hFFFF;
      raddr_a = {5'd9, 5'd3};
      #1;
      chk("clear_rd_zero", 64'(rdata_a), 64'h0);
      tick();
      we = 1'b0;
      #1;
      chk("sweep_wr_drop_a", 64'(wr_drop_a), 64'd1);
      chk("sweep_wr_drop_b", 64'(wr_drop_b), 64'd1);
      sweep(1, 32, 24, "clr_sweep");
      raddr_a = {5'd4, 5'd3};
      #1;
      chk("post_clr_r3_r4", 64'(rdata_a), 64'h0);
      raddr_a = {5'd10, 5'd9};
      #1;
      chk("post_clr_r9_r10", 64'(rdata_a), 64'h0);
      raddr_a = {5'd23, 5'd7};
      #1;
      chk("post_clr_r7_r23", 64'(rdata_a), 64'h0);

      // Reset in the middle of a sweep restarts it
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 64'({ready_a, ready_b}), 64'd0);
      tick();
      rst_n = 1'b1;
      sweep(0, 32, 24, "midrst_sweep");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
